// File: rtl/tc_array_sched.sv
// tc_array_sched: dispatches upstream jobs to an array of tensor-core lanes and
// returns their results on a single downstream stream.
//
// Ports
//   clk, rstn                        clock, synchronous active-low reset
//   in_valid/in_ready, in_a/b/c      upstream job handshake and operands
//   core_en                          per-lane enable mask
//   core_start, core_fetch_done      per-lane one-cycle pulses to the cores
//   core_a/b/c                       per-lane operand slices (lane i at [i*W +: W])
//   core_idle, core_wb, core_result  per-lane status, write-back level and result
//   core_ack                         per-lane one-cycle result acknowledge
//   out_valid/out_ready, out_data,
//   out_id                           downstream result handshake
//
// A lane is reserved from the cycle its job is accepted until its result is
// acked, so a lane never holds two jobs. With IN_ORDER=1 a FIFO of lane ids
// preserves dispatch order on the output; with IN_ORDER=0 results are taken
// round-robin from a separate collect pointer.
module tc_array_sched #(
  parameter int NUM_CORES = 4,
  parameter int A_W       = 512,
  parameter int B_W       = 256,
  parameter int C_W       = 512,
  parameter int IN_ORDER  = 1,
  localparam int ID_W     = $clog2(NUM_CORES)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_W-1:0]           in_a,
  input  logic [B_W-1:0]           in_b,
  input  logic [C_W-1:0]           in_c,
  input  logic [NUM_CORES-1:0]     core_en,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [NUM_CORES-1:0]     core_fetch_done,
  output logic [NUM_CORES*A_W-1:0] core_a,
  output logic [NUM_CORES*B_W-1:0] core_b,
  output logic [NUM_CORES*C_W-1:0] core_c,
  input  logic [NUM_CORES-1:0]     core_idle,
  input  logic [NUM_CORES-1:0]     core_wb,
  input  logic [NUM_CORES*C_W-1:0] core_result,
  output logic [NUM_CORES-1:0]     core_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [C_W-1:0]           out_data,
  output logic [ID_W-1:0]          out_id
);

  localparam int CNT_W = ID_W + 1;

  // {found, index} of the first set bit of mask at or after ptr, wrapping.
  // Scanning from the far end lets the nearest hit overwrite the result last.
  function automatic logic [ID_W:0] pick_rr(input logic [NUM_CORES-1:0] mask,
                                            input logic [ID_W-1:0]      ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (mask[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (int'(v) == NUM_CORES - 1) ? '0 : v + ID_W'(1);
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_CORES-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, col_ptr_q, col_ptr_d;
  logic [NUM_CORES-1:0] resv_q, resv_d;
  logic [ID_W-1:0]      fifo_q [NUM_CORES];
  logic [ID_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 job_vld_q, job_vld_d;
  logic [ID_W-1:0]      job_id_q, job_id_d;
  logic [A_W-1:0]       job_a_q, job_a_d;
  logic [B_W-1:0]       job_b_q, job_b_d;
  logic [C_W-1:0]       job_c_q, job_c_d;
  logic                 fd_vld_q, fd_vld_d;
  logic [ID_W-1:0]      fd_id_q, fd_id_d;
  logic                 out_valid_q, out_valid_d;
  logic [C_W-1:0]       out_data_q, out_data_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;

  logic [NUM_CORES-1:0] elig, wb_live;
  logic [ID_W:0]        tgt_pick, col_pick;
  logic [ID_W-1:0]      tgt_id, col_id, fifo_head;
  logic                 tgt_found, col_found, fifo_full, fifo_empty;
  logic                 accept, collect, out_free;

  // Dispatch decision: lane must be enabled, idle and not already holding a job.
  assign elig      = core_en & core_idle & ~resv_q;
  assign tgt_pick  = pick_rr(elig, rr_ptr_q);
  assign tgt_found = tgt_pick[ID_W];
  assign tgt_id    = tgt_pick[ID_W-1:0];
  assign fifo_full  = (cnt_q == CNT_W'(NUM_CORES));
  assign fifo_empty = (cnt_q == '0);
  // Gating with rstn keeps handshakes and pulses quiet while reset is held.
  assign in_ready  = rstn & tgt_found & ~fifo_full;
  assign accept    = in_valid & in_ready;

  // Collection decision: only reserved lanes count, so a stale core_wb from
  // a job discarded by reset is ignored. core_en is deliberately not used.
  assign wb_live   = core_wb & resv_q;
  assign fifo_head = fifo_q[rd_q];
  assign col_pick  = pick_rr(wb_live, col_ptr_q);

  always_comb begin
    if (IN_ORDER != 0) begin
      col_found = ~fifo_empty & wb_live[fifo_head];
      col_id    = fifo_head;
    end else begin
      col_found = col_pick[ID_W];
      col_id    = col_pick[ID_W-1:0];
    end
  end

  assign out_free = ~out_valid_q | out_ready;
  assign collect  = rstn & col_found & out_free;
  assign core_ack = collect ? onehot(col_id) : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    col_ptr_d   = col_ptr_q;
    resv_d      = resv_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    job_vld_d   = accept;
    job_id_d    = job_id_q;
    job_a_d     = job_a_q;
    job_b_d     = job_b_q;
    job_c_d     = job_c_q;
    fd_vld_d    = job_vld_q;
    fd_id_d     = job_id_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept) begin
      rr_ptr_d = wrap_inc(tgt_id);
      resv_d   = resv_d | onehot(tgt_id);
      job_id_d = tgt_id;
      job_a_d  = in_a;
      job_b_d  = in_b;
      job_c_d  = in_c;
    end
    // The collected lane is reserved and the accepted one is not, so the two
    // updates to resv_d never touch the same bit.
    if (collect) begin
      resv_d      = resv_d & ~onehot(col_id);
      col_ptr_d   = wrap_inc(col_id);
      out_valid_d = 1'b1;
      out_data_d  = core_result[col_id*C_W +: C_W];
      out_id_d    = col_id;
    end
    if (IN_ORDER != 0) begin
      if (accept)  wr_d = wrap_inc(wr_q);
      if (collect) rd_d = wrap_inc(rd_q);
      case ({accept, collect})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Stage boundary: accepted job, pointers, reservations and output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q    <= '0;
      col_ptr_q   <= '0;
      resv_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      job_vld_q   <= 1'b0;
      job_id_q    <= '0;
      job_a_q     <= '0;
      job_b_q     <= '0;
      job_c_q     <= '0;
      fd_vld_q    <= 1'b0;
      fd_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      col_ptr_q   <= col_ptr_d;
      resv_q      <= resv_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      job_vld_q   <= job_vld_d;
      job_id_q    <= job_id_d;
      job_a_q     <= job_a_d;
      job_b_q     <= job_b_d;
      job_c_q     <= job_c_d;
      fd_vld_q    <= fd_vld_d;
      fd_id_q     <= fd_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  // FIFO storage needs no reset: emptiness is carried by the pointers/count.
  always_ff @(posedge clk) begin
    if ((IN_ORDER != 0) && accept) fifo_q[wr_q] <= tgt_id;
  end

  // Stage boundary: start pulse with operands, then fetch-done one cycle later
  // with the operand slices already back at zero.
  always_comb begin
    core_start      = '0;
    core_fetch_done = '0;
    core_a          = '0;
    core_b          = '0;
    core_c          = '0;
    if (rstn && job_vld_q) begin
      core_start                   = onehot(job_id_q);
      core_a[job_id_q*A_W +: A_W]  = job_a_q;
      core_b[job_id_q*B_W +: B_W]  = job_b_q;
      core_c[job_id_q*C_W +: C_W]  = job_c_q;
    end
    if (rstn && fd_vld_q) core_fetch_done = onehot(fd_id_q);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_tc_array_sched.sv
// Bench for tc_array_sched: an in-order and an out-of-order instance share
// all inputs; directed scenarios plus randomized traffic against a reference
// model of the scheduling rules.
module tb_tc_array_sched;
  localparam int N = 4, AW = 16, BW = 12, CW = 16, IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, in_valid, out_ready;
  logic [AW-1:0]   in_a;
  logic [BW-1:0]   in_b;
  logic [CW-1:0]   in_c;
  logic [N-1:0]    core_en, core_idle, core_wb;
  logic [N*CW-1:0] core_result;

  logic            io_in_ready, oo_in_ready, io_ov, oo_ov;
  logic [N-1:0]    io_start, io_fd, io_ack, oo_start, oo_fd, oo_ack;
  logic [N*AW-1:0] io_a, oo_a;
  logic [N*BW-1:0] io_b, oo_b;
  logic [N*CW-1:0] io_c, oo_c;
  logic [CW-1:0]   io_od, oo_od;
  logic [IDW-1:0]  io_oid, oo_oid;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  tc_array_sched #(.NUM_CORES(N), .A_W(AW), .B_W(BW), .C_W(CW), .IN_ORDER(1)) dut_io (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(io_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .core_en(core_en),
    .core_start(io_start), .core_fetch_done(io_fd),
    .core_a(io_a), .core_b(io_b), .core_c(io_c),
    .core_idle(core_idle), .core_wb(core_wb), .core_result(core_result), .core_ack(io_ack),
    .out_valid(io_ov), .out_ready(out_ready), .out_data(io_od), .out_id(io_oid));

  tc_array_sched #(.NUM_CORES(N), .A_W(AW), .B_W(BW), .C_W(CW), .IN_ORDER(0)) dut_oo (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(oo_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .core_en(core_en),
    .core_start(oo_start), .core_fetch_done(oo_fd),
    .core_a(oo_a), .core_b(oo_b), .core_c(oo_c),
    .core_idle(core_idle), .core_wb(core_wb), .core_result(core_result), .core_ack(oo_ack),
    .out_valid(oo_ov), .out_ready(out_ready), .out_data(oo_od), .out_id(oo_oid));

  // What a modelled tensor core returns for a job.
  function automatic logic [CW-1:0] core_fn(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                            input logic [CW-1:0] c);
    return (a + CW'(b)) ^ c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    core_en = '1; core_idle = '1; core_wb = '0; core_result = '0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    core_wb = '1; in_valid = 1'b1; rstn = 1'b0;
    tick(); tick(); #1;
    n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", io_in_ready); end else n_pass++;
    n_checks++; if ({io_start, io_fd, io_ack} !== '0) begin n_fail++; $display("FAIL rst_pulses: got %b want 0", {io_start, io_fd, io_ack}); end else n_pass++;
    n_checks++; if ({io_a, io_b, io_c} !== '0) begin n_fail++; $display("FAIL rst_operands: got %h want 0", {io_a, io_b, io_c}); end else n_pass++;
    n_checks++; if ({io_ov, io_od, io_oid} !== '0) begin n_fail++; $display("FAIL rst_out: got %h want 0", {io_ov, io_od, io_oid}); end else n_pass++;
    rstn = 1'b1; in_valid = 1'b0; core_wb = '0; core_en = '0; #1;
    n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL en_zero_ready: got %b want 0", io_in_ready); end else n_pass++;
    core_en = '1; #1;
    n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL en_all_ready: got %b want 1", io_in_ready); end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]    es, ef;
    logic [N*AW-1:0] ea;
    logic [N*BW-1:0] eb;
    logic [N*CW-1:0] ec;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      in_a = AW'(16'hA000 + k); in_b = BW'(12'hB00 + k); in_c = CW'(16'hC000 + k);
      #1;
      es = '0; ef = '0; ea = '0; eb = '0; ec = '0;
      if (k >= 1 && k <= 4) begin
        es[k-1] = 1'b1;
        ea[(k-1)*AW +: AW] = AW'(16'hA000 + k - 1);
        eb[(k-1)*BW +: BW] = BW'(12'hB00 + k - 1);
        ec[(k-1)*CW +: CW] = CW'(16'hC000 + k - 1);
      end
      if (k >= 2) ef[k-2] = 1'b1;
      n_checks++; if (io_start !== es) begin n_fail++; $display("FAIL b2b_start%0d: got %b want %b", k, io_start, es); end else n_pass++;
      n_checks++; if (io_fd !== ef) begin n_fail++; $display("FAIL b2b_fetch%0d: got %b want %b", k, io_fd, ef); end else n_pass++;
      n_checks++; if ({io_a, io_b, io_c} !== {ea, eb, ec}) begin n_fail++; $display("FAIL b2b_operands%0d: got %h want %h", k, {io_a, io_b, io_c}, {ea, eb, ec}); end else n_pass++;
      if (k == 4) begin
        n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", io_in_ready); end else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_enable_mask();
    logic [N*AW-1:0] ea;
    do_reset();
    core_en = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 5);
      in_a = AW'(16'h1100 + k);
      if (k == 3) begin core_wb = 4'b0010; core_result = '0; core_result[1*CW +: CW] = 16'hBEEF; end
      if (k == 4) core_wb = '0;
      #1;
      case (k)
        0: begin n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL en_ready0: got %b want 1", io_in_ready); end else n_pass++; end
        1: begin
          ea = '0; ea[1*AW +: AW] = 16'h1100;
          n_checks++; if (io_start !== 4'b0010) begin n_fail++; $display("FAIL en_start_job0: got %b want 0010", io_start); end else n_pass++;
          n_checks++; if (io_a !== ea) begin n_fail++; $display("FAIL en_a_job0: got %h want %h", io_a, ea); end else n_pass++;
        end
        2: begin
          n_checks++; if (io_start !== 4'b1000) begin n_fail++; $display("FAIL en_start_job1: got %b want 1000", io_start); end else n_pass++;
          n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready_both_resv: got %b want 0", io_in_ready); end else n_pass++;
        end
        3: begin
          n_checks++; if (io_ack !== 4'b0010) begin n_fail++; $display("FAIL en_ack_lane1: got %b want 0010", io_ack); end else n_pass++;
          n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL en_ready_ack_cycle: got %b want 0", io_in_ready); end else n_pass++;
        end
        4: begin
          n_checks++; if ({io_ov, io_oid, io_od} !== {1'b1, 2'd1, 16'hBEEF}) begin n_fail++; $display("FAIL en_out: got %h want %h", {io_ov, io_oid, io_od}, {1'b1, 2'd1, 16'hBEEF}); end else n_pass++;
          n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL en_ready_after_ack: got %b want 1", io_in_ready); end else n_pass++;
        end
        default: begin
          ea = '0; ea[1*AW +: AW] = 16'h1104;
          n_checks++; if (io_start !== 4'b0010) begin n_fail++; $display("FAIL en_start_job2: got %b want 0010", io_start); end else n_pass++;
          n_checks++; if (io_a !== ea) begin n_fail++; $display("FAIL en_a_job2: got %h want %h", io_a, ea); end else n_pass++;
        end
      endcase
      tick();
    end
  endtask

  task automatic test_order();
    int io_ids[$], oo_ids[$];
    logic [CW-1:0] io_d[$], oo_d[$];
    do_reset();
    core_result[0*CW +: CW] = 16'h00A0;
    core_result[1*CW +: CW] = 16'h00B1;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k < 2); in_a = AW'(k);
      core_wb[1] = (k >= 3);
      core_wb[0] = (k >= 8);
      #1;
      if (io_ov && out_ready) begin io_ids.push_back(int'(io_oid)); io_d.push_back(io_od); end
      if (oo_ov && out_ready) begin oo_ids.push_back(int'(oo_oid)); oo_d.push_back(oo_od); end
      tick();
    end
    n_checks++; if (io_ids.size() !== 2 || oo_ids.size() !== 2) begin n_fail++; $display("FAIL order_counts: got %0d/%0d want 2/2", io_ids.size(), oo_ids.size()); end else n_pass++;
    if (io_ids.size() == 2 && oo_ids.size() == 2) begin
      n_checks++; if ({io_ids[0], io_ids[1]} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL inorder_ids: got %0d,%0d want 0,1", io_ids[0], io_ids[1]); end else n_pass++;
      n_checks++; if ({io_d[0], io_d[1]} !== {16'h00A0, 16'h00B1}) begin n_fail++; $display("FAIL inorder_data: got %h,%h want 00a0,00b1", io_d[0], io_d[1]); end else n_pass++;
      n_checks++; if ({oo_ids[0], oo_ids[1]} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL ooo_ids: got %0d,%0d want 1,0", oo_ids[0], oo_ids[1]); end else n_pass++;
      n_checks++; if ({oo_d[0], oo_d[1]} !== {16'h00B1, 16'h00A0}) begin n_fail++; $display("FAIL ooo_data: got %h,%h want 00b1,00a0", oo_d[0], oo_d[1]); end else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    core_result[0*CW +: CW] = 16'h1234;
    core_result[1*CW +: CW] = 16'h5678;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 2); in_a = AW'(k);
      core_wb = (k >= 2) ? 4'b0011 : 4'b0000;
      out_ready = (k >= 6);
      #1;
      if (k == 2) begin
        n_checks++; if (io_ack !== 4'b0001) begin n_fail++; $display("FAIL bp_first_ack: got %b want 0001", io_ack); end else n_pass++;
      end
      if (k >= 3 && k <= 5) begin
        n_checks++; if ({io_ov, io_oid, io_od} !== {1'b1, 2'd0, 16'h1234}) begin n_fail++; $display("FAIL bp_hold%0d: got %h want %h", k, {io_ov, io_oid, io_od}, {1'b1, 2'd0, 16'h1234}); end else n_pass++;
        n_checks++; if (io_ack !== 4'b0000) begin n_fail++; $display("FAIL bp_no_ack%0d: got %b want 0000", k, io_ack); end else n_pass++;
      end
      if (k == 6) begin
        n_checks++; if (io_od !== 16'h1234) begin n_fail++; $display("FAIL bp_release_data: got %h want 1234", io_od); end else n_pass++;
        n_checks++; if (io_ack !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ack: got %b want 0010", io_ack); end else n_pass++;
      end
      if (k == 7) begin
        n_checks++; if ({io_ov, io_oid, io_od} !== {1'b1, 2'd1, 16'h5678}) begin n_fail++; $display("FAIL bp_second: got %h want %h", {io_ov, io_oid, io_od}, {1'b1, 2'd1, 16'h5678}); end else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    logic [N*AW-1:0] ea;
    do_reset();
    in_valid = 1'b1; in_a = 16'h0001; tick();
    in_a = 16'h0002; tick();
    in_valid = 1'b0; rstn = 1'b0; core_wb = 4'b0011; #1;
    n_checks++; if ({io_start, io_ack} !== '0) begin n_fail++; $display("FAIL mid_rst_pulses: got %b want 0", {io_start, io_ack}); end else n_pass++;
    tick();
    rstn = 1'b1; #1;
    n_checks++; if ({io_start, io_fd, io_ack} !== '0) begin n_fail++; $display("FAIL mid_after_pulses: got %b want 0", {io_start, io_fd, io_ack}); end else n_pass++;
    n_checks++; if ({io_a, io_b, io_c} !== '0) begin n_fail++; $display("FAIL mid_after_operands: got %h want 0", {io_a, io_b, io_c}); end else n_pass++;
    n_checks++; if ({io_ov, io_od, io_oid} !== '0) begin n_fail++; $display("FAIL mid_after_out: got %h want 0", {io_ov, io_od, io_oid}); end else n_pass++;
    in_valid = 1'b1; in_a = 16'h7777; #1;
    n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", io_in_ready); end else n_pass++;
    tick();
    in_valid = 1'b0; core_wb = '0; #1;
    ea = '0; ea[0 +: AW] = 16'h7777;
    n_checks++; if (io_start !== 4'b0001) begin n_fail++; $display("FAIL mid_new_lane: got %b want 0001", io_start); end else n_pass++;
    n_checks++; if (io_a !== ea) begin n_fail++; $display("FAIL mid_new_a: got %h want %h", io_a, ea); end else n_pass++;
  endtask

  // Randomized traffic on the in-order instance. Modelled cores hold each
  // job for a random time and keep core_wb high until acked; the reference
  // model predicts lanes, pulses and results from the scheduling rules.
  task automatic test_random_traffic();
    bit            busy [N];
    int            cnt [N];
    logic [CW-1:0] res [N];
    logic [AW-1:0] ja [N];
    logic [BW-1:0] jb [N];
    logic [CW-1:0] jc [N];
    int            m_order[$];
    logic [N-1:0]  m_resv, free_l, es, ef, ek;
    int            m_rr, s_lane, f_lane, lane, hd;
    bit            s_vld, f_vld, m_ov, exp_rdy, exp_col, acc;
    logic [CW-1:0] m_od;
    int            m_oid;
    logic [N*AW-1:0] ea;
    logic [N*BW-1:0] eb;
    logic [N*CW-1:0] ec;
    do_reset();
    for (int i = 0; i < N; i++) begin busy[i] = 0; cnt[i] = 0; res[i] = '0; end
    m_resv = '0; m_rr = 0; s_vld = 0; f_vld = 0; m_ov = 0; m_od = '0; m_oid = 0; s_lane = 0; f_lane = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_a = AW'($urandom); in_b = BW'($urandom); in_c = CW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        core_idle[i] = !busy[i];
        core_wb[i] = busy[i] && (cnt[i] == 0);
        core_result[i*CW +: CW] = res[i];
      end
      #1;
      free_l = core_en & core_idle & ~m_resv;
      exp_rdy = (free_l != '0);
      es = '0; ea = '0; eb = '0; ec = '0; ef = '0; ek = '0;
      if (s_vld) begin
        es[s_lane] = 1'b1;
        ea[s_lane*AW +: AW] = ja[s_lane]; eb[s_lane*BW +: BW] = jb[s_lane]; ec[s_lane*CW +: CW] = jc[s_lane];
      end
      if (f_vld) ef[f_lane] = 1'b1;
      hd = (m_order.size() > 0) ? m_order[0] : 0;
      exp_col = (!m_ov || out_ready) && (m_order.size() > 0) && core_wb[hd];
      if (exp_col) ek[hd] = 1'b1;
      n_checks++; if (io_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, io_in_ready, exp_rdy); end else n_pass++;
      n_checks++; if ({io_start, io_fd, io_ack} !== {es, ef, ek}) begin n_fail++; $display("FAIL rnd_pulses@%0d: got %b want %b", cyc, {io_start, io_fd, io_ack}, {es, ef, ek}); end else n_pass++;
      n_checks++; if ({io_a, io_b, io_c} !== {ea, eb, ec}) begin n_fail++; $display("FAIL rnd_operands@%0d: got %h want %h", cyc, {io_a, io_b, io_c}, {ea, eb, ec}); end else n_pass++;
      n_checks++; if (io_ov !== m_ov || (m_ov && {io_od, 32'(io_oid)} !== {m_od, m_oid})) begin n_fail++; $display("FAIL rnd_out@%0d: got %b/%h/%0d want %b/%h/%0d", cyc, io_ov, io_od, io_oid, m_ov, m_od, m_oid); end else n_pass++;
      // environment reacts to what the DUT actually drove
      for (int i = 0; i < N; i++) begin
        if (io_ack[i]) busy[i] = 0;
        else if (busy[i] && cnt[i] > 0) cnt[i]--;
        if (io_start[i]) begin
          busy[i] = 1; cnt[i] = $urandom_range(0, 5);
          res[i] = core_fn(io_a[i*AW +: AW], io_b[i*BW +: BW], io_c[i*CW +: CW]);
        end
      end
      // reference model advances across the clock edge
      acc = in_valid && exp_rdy;
      f_vld = s_vld; f_lane = s_lane; s_vld = acc;
      if (acc) begin
        lane = -1;
        for (int k = N - 1; k >= 0; k--) if (free_l[(m_rr + k) % N]) lane = (m_rr + k) % N;
        s_lane = lane; m_resv[lane] = 1'b1; m_order.push_back(lane); m_rr = (lane + 1) % N;
        ja[lane] = in_a; jb[lane] = in_b; jc[lane] = in_c;
      end
      if (exp_col) begin
        lane = m_order.pop_front();
        m_resv[lane] = 1'b0; m_ov = 1; m_oid = lane;
        m_od = core_fn(ja[lane], jb[lane], jc[lane]);
      end else if (out_ready) m_ov = 0;
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_enable_mask();
    test_order();
    test_backpressure();
    test_reset_midflight();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
